irq_pending_ctrl: RTL and testbench

Upstream request stage for the 4-to-2 priority encoder. Synchronizes four asynchronous request lines, captures rising edges into sticky pending bits, and drives the masked pending vector onto the encoder's `x` input. It then takes the encoder's `y`/`z` result back, raises a held interrupt with the winning index, and clears that pending bit once the consumer acknowledges it.

---
 rtl/irq_pending_ctrl.sv | 94 +++++++++
 tb/tb_irq_pending_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_ctrl.sv
// Request front end for the 4-to-2 priority encoder. It synchronises the request lines and keeps a
// sticky pending bit per line, then runs a three-state IDLE/ASSERT/CLEAR interrupt handshake.
module irq_pending_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req_in,
  input  logic [3:0] mask,
  output logic [3:0] x,
  input  logic       enc_z,
  input  logic [1:0] enc_y,
  output logic       irq,
  output logic [1:0] irq_id,
  input  logic       ack,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    CLEAR  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_out;
  logic [3:0] prev;
  logic [3:0] pending;
  logic [3:0] rise;
  logic [3:0] set_vec;
  logic [3:0] clr_vec;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign rise      = sync_out & ~prev;
  assign set_vec   = rise & {4{en}};
  assign clr_vec   = (state == CLEAR) ? (4'b0001 << irq_id) : 4'b0000;
  assign x         = pending & mask;
  assign state_dbg = state;

  // Synchroniser chain plus the edge-detect flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 4'b0000;
      prev <= 4'b0000;
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev <= sync_out;
    end
  end

  // The set term is ORed after the clear so a fresh edge on the line being cleared survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 4'b0000;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      irq    <= 1'b0;
      irq_id <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en && enc_z) begin
            irq_id <= enc_y;
            irq    <= 1'b1;
            state  <= ASSERT;
          end
        end
        ASSERT: begin
          if (ack) begin
            irq   <= 1'b0;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          state <= IDLE;
        end
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: a per-cycle vector table plus hand-written sequences for
// mask/enable, set-wins collision, held levels and asynchronous reset.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic [3:0] x;
  logic       enc_z;
  logic [1:0] enc_y;
  logic       irq;
  logic [1:0] irq_id;
  logic       ack;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] msk;
    logic       en;
    logic       ack;
    logic [3:0] exp_x;
    logic       exp_irq;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vq[$];
  logic [1:0] exp_q[$];

  irq_pending_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_in(req_in), .mask(mask), .x(x),
    .enc_z(enc_z), .enc_y(enc_y), .irq(irq), .irq_id(irq_id), .ack(ack), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference priority encoder: highest set bit of x wins.
  always_comb begin
    enc_z = |x;
    enc_y = 2'd0;
    for (int i = 0; i < 4; i++) if (x[i]) enc_y = i[1:0];
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic add(input logic [3:0] r, input logic a, input logic [3:0] ex,
                     input logic ei, input logic [1:0] eid);
    vq.push_back('{r, 4'hF, 1'b1, a, ex, ei, eid});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int run;
    int maxrun;
    bit seen;

    rst_n = 1'b0; en = 1'b1; req_in = 4'h0; mask = 4'hF; ack = 1'b0;
    settle(2);
    chk("reset_x", {4'h0, x}, 8'h00);
    chk("reset_irq", {7'h0, irq}, 8'h00);
    chk("reset_id", {6'h0, irq_id}, 8'h00);
    rst_n = 1'b1;

    // Single edge on line 2, then a priority drain of 4'b1011 with ack held high.
    add(4'h4, 0, 4'h0, 0, 0); add(4'h4, 0, 4'h0, 0, 0); add(4'h4, 0, 4'h4, 0, 0);
    add(4'h4, 0, 4'h4, 1, 2); add(4'h4, 0, 4'h4, 1, 2); add(4'h4, 1, 4'h4, 0, 0);
    add(4'h4, 0, 4'h0, 0, 0); add(4'h0, 0, 4'h0, 0, 0); add(4'h0, 0, 4'h0, 0, 0);
    add(4'h0, 0, 4'h0, 0, 0);
    add(4'hB, 1, 4'h0, 0, 0); add(4'hB, 1, 4'h0, 0, 0); add(4'hB, 1, 4'hB, 0, 0);
    add(4'hB, 1, 4'hB, 1, 3); add(4'hB, 1, 4'hB, 0, 0); add(4'hB, 1, 4'h3, 0, 0);
    add(4'hB, 1, 4'h3, 1, 1); add(4'hB, 1, 4'h3, 0, 0); add(4'hB, 1, 4'h1, 0, 0);
    add(4'hB, 1, 4'h1, 1, 0); add(4'hB, 1, 4'h1, 0, 0); add(4'hB, 1, 4'h0, 0, 0);
    add(4'hB, 1, 4'h0, 0, 0); add(4'h0, 0, 4'h0, 0, 0); add(4'h0, 0, 4'h0, 0, 0);
    add(4'h0, 0, 4'h0, 0, 0);

    foreach (vq[r]) begin
      req_in = vq[r].req; mask = vq[r].msk; en = vq[r].en; ack = vq[r].ack;
      step();
      chk($sformatf("vec%0d_x", r), {4'h0, x}, {4'h0, vq[r].exp_x});
      chk($sformatf("vec%0d_irq", r), {7'h0, irq}, {7'h0, vq[r].exp_irq});
      if (vq[r].exp_irq) chk($sformatf("vec%0d_id", r), {6'h0, irq_id}, {6'h0, vq[r].exp_id});
    end
    ack = 1'b0;

    // Masked line 0 stays pending but invisible until unmasked.
    mask = 4'b1110; req_in = 4'b0001;
    settle(5);
    chk("mask_x", {4'h0, x}, 8'h00);
    chk("mask_irq", {7'h0, irq}, 8'h00);
    mask = 4'hF;
    #1;
    chk("unmask_x", {4'h0, x}, 8'h01);
    seen = 0;
    for (int c = 0; c < 2 && !seen; c++) begin
      step();
      if (irq) seen = 1;
    end
    if (!seen) fail_now("unmask_irq_timeout");
    else chk("unmask_id", {6'h0, irq_id}, 8'h00);
    ack = 1'b1; step(); ack = 1'b0; step();
    chk("mask_cleared_x", {4'h0, x}, 8'h00);
    req_in = 4'h0;
    settle(3);

    // Enable low swallows the edge; raising enable later does not resurrect it.
    en = 1'b0; req_in = 4'b0010;
    settle(5);
    chk("en0_x", {4'h0, x}, 8'h00);
    en = 1'b1;
    settle(4);
    chk("en1_x", {4'h0, x}, 8'h00);
    chk("en1_irq", {7'h0, irq}, 8'h00);
    req_in = 4'h0;
    settle(3);

    // Second rise on line 2 lands on the same edge that CLEAR drops pending[2].
    req_in = 4'b0100; step();
    req_in = 4'b0000; step(); step();
    chk("coll_x1", {4'h0, x}, 8'h04);
    req_in = 4'b0100; step();
    chk("coll_irq1", {7'h0, irq}, 8'h01);
    chk("coll_id1", {6'h0, irq_id}, 8'h02);
    ack = 1'b1; step();
    chk("coll_ack_irq", {7'h0, irq}, 8'h00);
    ack = 1'b0; step();
    chk("coll_setwins_x", {4'h0, x}, 8'h04);
    step();
    chk("coll_irq2", {7'h0, irq}, 8'h01);
    chk("coll_id2", {6'h0, irq_id}, 8'h02);
    ack = 1'b1; step(); ack = 1'b0; step();
    chk("coll_done_x", {4'h0, x}, 8'h00);
    req_in = 4'h0;
    settle(3);

    // Line 1 held high across three services with ack held: one irq per rising line.
    exp_q.delete();
    exp_q.push_back(2'd1); exp_q.push_back(2'd0); exp_q.push_back(2'd3);
    req_in = 4'b0010; ack = 1'b1; run = 0; maxrun = 0;
    for (int c = 0; c < 24; c++) begin
      if (c == 6) req_in = 4'b0011;
      if (c == 12) req_in = 4'b1011;
      step();
      if (irq) begin
        run++;
        if (exp_q.size() > 0) chk("held_id", {6'h0, irq_id}, {6'h0, exp_q.pop_front()});
        else fail_now("held_extra_irq");
      end else begin
        run = 0;
      end
      if (run > maxrun) maxrun = run;
    end
    chk("held_missing", exp_q.size(), 0);
    chk("held_pulse_len", maxrun, 1);
    req_in = 4'h0; ack = 1'b0;
    settle(4);

    // Asynchronous reset mid-ASSERT with pending = 4'b1010.
    req_in = 4'b1010;
    settle(4);
    chk("pre_rst_irq", {7'h0, irq}, 8'h01);
    chk("pre_rst_id", {6'h0, irq_id}, 8'h03);
    chk("pre_rst_x", {4'h0, x}, 8'h0A);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_irq", {7'h0, irq}, 8'h00);
    chk("async_rst_id", {6'h0, irq_id}, 8'h00);
    chk("async_rst_x", {4'h0, x}, 8'h00);

    // Line 1 already high when reset releases: captured exactly once.
    req_in = 4'b0010;
    settle(2);
    rst_n = 1'b1; ack = 1'b1;
    exp_q.delete();
    exp_q.push_back(2'd1);
    for (int c = 0; c < 12; c++) begin
      step();
      if (irq) begin
        if (exp_q.size() > 0) chk("rel_id", {6'h0, irq_id}, {6'h0, exp_q.pop_front()});
        else fail_now("rel_extra_irq");
      end
    end
    chk("rel_missing", exp_q.size(), 0);
    chk("rel_final_x", {4'h0, x}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
